// File: rtl/multi_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// multi_countdown_timer_if
// Command/status bundle between the keypad/mode controller (master) and the
// multi-channel countdown timer (slave). The display mux and buzzer driver
// read the status half of the bundle.
// ---------------------------------------------------------------------------
interface multi_countdown_timer_if #(
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1
);

  // Command side: one encoded command per cycle, aimed at one channel.
  logic [1:0]             timer_mode;
  logic [CH_W-1:0]        ch_sel;
  logic [23:0]            time_in;

  // Status side: channel k occupies time_out[24k +: 24] as {hour, min, sec}.
  logic [24*CHANNELS-1:0] time_out;
  logic [CHANNELS-1:0]    buzzer;
  logic [CHANNELS-1:0]    running;
  logic                   load_err;

  modport master (
    output timer_mode, ch_sel, time_in,
    input  time_out, buzzer, running, load_err
  );

  modport slave (
    input  timer_mode, ch_sel, time_in,
    output time_out, buzzer, running, load_err
  );

endinterface

// File: rtl/multi_countdown_timer.sv
// ---------------------------------------------------------------------------
// multi_countdown_timer
// CHANNELS independent HH:MM:SS packed-BCD countdowns clocked by a 1 Hz
// clock. Each channel has load/start/pause control, load validation and a
// buzzer that stays on for BUZZ_SECS cycles after expiry unless acknowledged.
//
// Optional feature, macro MULTI_TIMER_AUTO_RELOAD_EN:
//   defined   - each channel remembers its last valid load value and, when
//               the buzzer times out, restarts from it (periodic timer).
//   undefined - after the buzzer times out the channel rests in IDLE at
//               00:00:00.
// ---------------------------------------------------------------------------
module multi_countdown_timer #(
  parameter int CHANNELS  = 2,
  parameter int BUZZ_SECS = 5,
  parameter int CH_W      = 1
) (
  input  logic                    clk_1hz,
  input  logic                    reset,
  multi_countdown_timer_if.slave  bus
);

  // Channel states (legacy-compatible encoding).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  // Command encoding on timer_mode.
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_START = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  localparam logic [23:0] T_ZERO    = 24'h00_00_00;
  localparam logic [23:0] T_ONE     = 24'h00_00_01;
  localparam logic [7:0]  BUZZ_INIT = 8'(BUZZ_SECS);

  // -------------------------------------------------------------------------
  // BCD helpers
  // -------------------------------------------------------------------------

  // Decrement one packed-BCD byte that is known to be non-zero.
  function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
    if (v[3:0] != 4'd0) begin
      return {v[7:4], v[3:0] - 4'd1};
    end
    return {v[7:4] - 4'd1, 4'h9};
  endfunction

  // One-second decrement with borrow from minutes and hours; holds at zero.
  function automatic logic [23:0] bcd_dec_time(input logic [23:0] t);
    if (t[7:0] != 8'h00) begin
      return {t[23:8], bcd_dec8(t[7:0])};
    end
    if (t[15:8] != 8'h00) begin
      return {t[23:16], bcd_dec8(t[15:8]), 8'h59};
    end
    if (t[23:16] != 8'h00) begin
      return {bcd_dec8(t[23:16]), 16'h5959};
    end
    return t;
  endfunction

  // A load is legal when every digit is decimal and both tens-of-sixty
  // digits (sec, min) are at most 5. Hours may span 00..99.
  function automatic logic bcd_time_valid(input logic [23:0] t);
    return (t[3:0]   <= 4'd9) && (t[7:4]   <= 4'd5) &&
           (t[11:8]  <= 4'd9) && (t[15:12] <= 4'd5) &&
           (t[19:16] <= 4'd9) && (t[23:20] <= 4'd9);
  endfunction

  // -------------------------------------------------------------------------
  // Shared command decode
  // -------------------------------------------------------------------------
  logic [31:0] sel_ext;
  logic        sel_hit;
  logic        load_ok;
  logic        load_err_q;
  logic        load_err_d;

  // Decode which channel (if any) the current command addresses.
  always_comb begin
    // NOTE: every signal driven here gets a value before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    sel_ext    = 32'(bus.ch_sel);
    sel_hit    = (sel_ext < 32'(CHANNELS));
    load_ok    = bcd_time_valid(bus.time_in);
    load_err_d = sel_hit && (bus.timer_mode == CMD_LOAD) && !load_ok;
  end

  // Register the rejected-load flag so it appears as a one-cycle pulse.
  always_ff @(posedge clk_1hz) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from before the edge.
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign bus.load_err = load_err_q;

  // -------------------------------------------------------------------------
  // Per-channel countdown
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [23:0] time_q, time_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  buzz_q, buzz_d;
    logic        chan_hit;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
    logic [23:0] reload_q, reload_d;
`endif

    assign chan_hit = sel_hit && (sel_ext == 32'(k));

    // Next state: autonomous countdown/alarm first, then the command to this
    // channel overrides it, so a command beats an expiry in the same cycle.
    always_comb begin
      time_d  = time_q;
      state_d = state_q;
      buzz_d  = buzz_q;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif

      case (state_q)
        ST_IDLE: begin
        end
        ST_RUN: begin
          if (time_q == T_ONE) begin
            time_d  = T_ZERO;
            state_d = ST_ALARM;
            buzz_d  = BUZZ_INIT;
          end else if (time_q != T_ZERO) begin
            time_d = bcd_dec_time(time_q);
          end
        end
        ST_ALARM: begin
          if (buzz_q <= 8'd1) begin
            buzz_d = 8'd0;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
            time_d  = reload_q;
            state_d = (reload_q != T_ZERO) ? ST_RUN : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            buzz_d = buzz_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (chan_hit) begin
        case (bus.timer_mode)
          CMD_LOAD: begin
            if (load_ok) begin
              time_d  = bus.time_in;
              state_d = ST_IDLE;
              buzz_d  = 8'd0;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
              reload_d = bus.time_in;
`endif
            end
          end
          CMD_START: begin
            if ((state_q == ST_IDLE) && (time_q != T_ZERO)) begin
              state_d = ST_RUN;
            end else if (state_q == ST_ALARM) begin
              // Acknowledge silences the buzzer and never triggers a reload.
              time_d  = time_q;
              state_d = ST_IDLE;
              buzz_d  = 8'd0;
            end
          end
          CMD_PAUSE: begin
            if (state_q == ST_RUN) begin
              time_d  = time_q;
              state_d = ST_IDLE;
            end
          end
          CMD_NONE: begin
          end
          default: begin
          end
        endcase
      end
    end

    // Channel registers with synchronous reset.
    always_ff @(posedge clk_1hz) begin
      // NOTE: the reload store is cleared with the rest of the channel so a
      // timeout after reset can never restart from stale contents.
      if (reset) begin
        time_q  <= T_ZERO;
        state_q <= ST_IDLE;
        buzz_q  <= 8'd0;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
        reload_q <= T_ZERO;
`endif
      end else begin
        time_q  <= time_d;
        state_q <= state_d;
        buzz_q  <= buzz_d;
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
        reload_q <= reload_d;
`endif
      end
    end

    // Status outputs are decodes of registered state, so running and buzzer
    // are mutually exclusive by construction.
    assign bus.time_out[24*k +: 24] = time_q;
    assign bus.buzzer[k]            = (state_q == ST_ALARM);
    assign bus.running[k]           = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_countdown_timer
// Directed bench for multi_countdown_timer. A seconds-based reference model
// tracks every channel and is compared with the DUT after every clock; the
// directed sequence also checks hand-computed literal values.
// Honours MULTI_TIMER_AUTO_RELOAD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_multi_countdown_timer;

  localparam int NCH  = 2;
  localparam int CHW  = 2;   // wide enough to address a non-existent channel
  localparam int BUZZ = 5;

  localparam logic [1:0] M_NONE  = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_START = 2'b10;
  localparam logic [1:0] M_PAUSE = 2'b11;

  logic clk_1hz = 1'b0;
  logic reset   = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  multi_countdown_timer_if #(.CHANNELS(NCH), .CH_W(CHW)) bus ();

  multi_countdown_timer #(
    .CHANNELS (NCH),
    .BUZZ_SECS(BUZZ),
    .CH_W     (CHW)
  ) dut (
    .clk_1hz(clk_1hz),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_1hz = ~clk_1hz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: time kept as total seconds, state as a small integer
  // (0 idle, 1 run, 2 alarm).
  // -------------------------------------------------------------------------
  int m_secs   [NCH];
  int m_mode   [NCH];
  int m_buzz   [NCH];
  int m_reload [NCH];
  bit m_err;

  function automatic int digit(input logic [23:0] t, input int pos);
    logic [23:0] s;
    s = t >> (4 * pos);
    return int'(s[3:0]);
  endfunction

  function automatic bit time_legal(input logic [23:0] t);
    for (int i = 0; i < 6; i++) begin
      if (digit(t, i) > 9) return 1'b0;
    end
    return (digit(t, 1) <= 5) && (digit(t, 3) <= 5);
  endfunction

  function automatic int to_secs(input logic [23:0] t);
    return (digit(t, 5) * 10 + digit(t, 4)) * 3600 +
           (digit(t, 3) * 10 + digit(t, 2)) * 60 +
           (digit(t, 1) * 10 + digit(t, 0));
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model_step();
    int sel, cmd, os, om, r;
    bit ok;
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        m_secs[k] = 0; m_mode[k] = 0; m_buzz[k] = 0; m_reload[k] = 0;
      end
      m_err = 1'b0;
      return;
    end
    sel   = int'(bus.ch_sel);
    cmd   = int'(bus.timer_mode);
    ok    = time_legal(bus.time_in);
    m_err = (sel < NCH) && (cmd == 1) && !ok;
    for (int k = 0; k < NCH; k++) begin
      os = m_secs[k];
      om = m_mode[k];
      if (om == 1 && os > 0) begin
        m_secs[k] = os - 1;
        if (m_secs[k] == 0) begin
          m_mode[k] = 2;
          m_buzz[k] = BUZZ;
        end
      end else if (om == 2) begin
        m_buzz[k] = m_buzz[k] - 1;
        if (m_buzz[k] == 0) begin
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
          r = m_reload[k];
`else
          r = 0;
`endif
          m_secs[k] = r;
          m_mode[k] = (r > 0) ? 1 : 0;
        end
      end
      if (sel == k) begin
        if (cmd == 1 && ok) begin
          m_secs[k]   = to_secs(bus.time_in);
          m_mode[k]   = 0;
          m_buzz[k]   = 0;
          m_reload[k] = m_secs[k];
        end else if (cmd == 2) begin
          if (om == 0 && os != 0) begin
            m_mode[k] = 1;
          end else if (om == 2) begin
            m_mode[k] = 0;
            m_secs[k] = os;
            m_buzz[k] = 0;
          end
        end else if (cmd == 3 && om == 1) begin
          m_mode[k] = 0;
          m_secs[k] = os;
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("model ch%0d time", k),
            32'(bus.time_out[24*k +: 24]), 32'(to_bcd(m_secs[k])));
      check($sformatf("model ch%0d buzzer", k),
            32'(bus.buzzer[k]), 32'(m_mode[k] == 2));
      check($sformatf("model ch%0d running", k),
            32'(bus.running[k]), 32'(m_mode[k] == 1));
    end
    check("model load_err", 32'(bus.load_err), 32'(m_err));
  endtask

  // Model advances on the same edge as the DUT; outputs compared after it.
  always @(posedge clk_1hz) begin
    model_step();
    #2;
    compare();
  end

  // -------------------------------------------------------------------------
  // Directed stimulus (called at a falling edge; returns one edge later)
  // -------------------------------------------------------------------------
  task automatic issue(input logic [1:0] mode, input int ch,
                       input logic [23:0] t);
    bus.timer_mode = mode;
    bus.ch_sel     = CHW'(ch);
    bus.time_in    = t;
    @(negedge clk_1hz);
    bus.timer_mode = M_NONE;
    bus.ch_sel     = '0;
    bus.time_in    = 24'h0;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk_1hz);
  endtask

  function automatic logic [31:0] ch_time(input int k);
    return 32'(bus.time_out[24*k +: 24]);
  endfunction

  initial begin
    int hi;
    bus.timer_mode = M_NONE;
    bus.ch_sel     = '0;
    bus.time_in    = 24'h0;
    clocks(2);
    check("reset ch0", ch_time(0), 32'h000000);
    check("reset ch1", ch_time(1), 32'h000000);
    check("reset buzzer", 32'(bus.buzzer), 32'h0);
    check("reset running", 32'(bus.running), 32'h0);
    check("reset load_err", 32'(bus.load_err), 32'h0);
    reset = 1'b0;

    // Minute borrow, channel isolation.
    issue(M_LOAD, 0, 24'h000105);
    issue(M_START, 0, 24'h0);
    clocks(6);
    check("min borrow ch0", ch_time(0), 32'h000059);
    check("idle ch1", ch_time(1), 32'h000000);
    check("running 01", 32'(bus.running), 32'h1);

    // Hour borrow on channel 1.
    issue(M_LOAD, 1, 24'h010000);
    issue(M_START, 1, 24'h0);
    clocks(1);
    check("hour borrow 01", ch_time(1), 32'h005959);
    issue(M_LOAD, 1, 24'h200000);
    issue(M_START, 1, 24'h0);
    clocks(1);
    check("hour borrow 20", ch_time(1), 32'h195959);
    issue(M_PAUSE, 1, 24'h0);
    check("pause ch1", ch_time(1), 32'h195959);

    // Expiry and buzzer timeout.
    issue(M_LOAD, 0, 24'h000002);
    issue(M_START, 0, 24'h0);
    clocks(1);
    check("expiry t-1", ch_time(0), 32'h000001);
    clocks(1);
    check("expiry time", ch_time(0), 32'h000000);
    check("expiry buzzer", 32'(bus.buzzer[0]), 32'h1);
    check("expiry not running", 32'(bus.running[0]), 32'h0);
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      clocks(1);
      if (bus.buzzer[0]) hi++;
    end
    check("buzz cycles", 32'(hi), 32'd5);
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
    check("timeout reload time", ch_time(0), 32'h000002);
    check("timeout reload run", 32'(bus.running[0]), 32'h1);
`else
    check("timeout time", ch_time(0), 32'h000000);
    check("timeout idle", 32'(bus.running[0]), 32'h0);
`endif

    // Acknowledge on the second alarm cycle.
    issue(M_LOAD, 0, 24'h000002);
    issue(M_START, 0, 24'h0);
    clocks(3);
    check("ack pre buzzer", 32'(bus.buzzer[0]), 32'h1);
    issue(M_START, 0, 24'h0);
    check("ack buzzer", 32'(bus.buzzer[0]), 32'h0);
    clocks(1);
    check("ack stays idle", 32'(bus.running[0]), 32'h0);
    check("ack time", ch_time(0), 32'h000000);

    // Pause and resume.
    issue(M_LOAD, 0, 24'h000010);
    issue(M_START, 0, 24'h0);
    clocks(3);
    check("run 3", ch_time(0), 32'h000007);
    issue(M_PAUSE, 0, 24'h0);
    clocks(4);
    check("paused", ch_time(0), 32'h000007);
    check("paused idle", 32'(bus.running[0]), 32'h0);
    issue(M_START, 0, 24'h0);
    clocks(1);
    check("resume", ch_time(0), 32'h000006);
    issue(M_PAUSE, 0, 24'h0);

    // Load validation and out-of-range channel.
    issue(M_LOAD, 0, 24'h000123);
    issue(M_LOAD, 0, 24'h005A00);
    check("bad nibble err", 32'(bus.load_err), 32'h1);
    check("bad nibble time", ch_time(0), 32'h000123);
    clocks(1);
    check("err one cycle", 32'(bus.load_err), 32'h0);
    issue(M_LOAD, 0, 24'h006000);
    check("min 60 err", 32'(bus.load_err), 32'h1);
    check("min 60 time", ch_time(0), 32'h000123);
    issue(M_LOAD, 3, 24'h000045);
    check("bad ch no err", 32'(bus.load_err), 32'h0);
    check("bad ch ch0", ch_time(0), 32'h000123);
    check("bad ch ch1", ch_time(1), 32'h195959);
    issue(M_LOAD, 1, 24'h995959);
    check("max load", ch_time(1), 32'h995959);
    check("max load no err", 32'(bus.load_err), 32'h0);

    // Pause on the last run cycle prevents the alarm.
    issue(M_LOAD, 0, 24'h000001);
    issue(M_START, 0, 24'h0);
    issue(M_PAUSE, 0, 24'h0);
    check("late pause time", ch_time(0), 32'h000001);
    check("late pause buzzer", 32'(bus.buzzer[0]), 32'h0);

    // Timeout behaviour with/without auto-reload.
    issue(M_LOAD, 0, 24'h000003);
    issue(M_START, 0, 24'h0);
    clocks(3);
    check("reload test alarm", 32'(bus.buzzer[0]), 32'h1);
    clocks(5);
`ifdef MULTI_TIMER_AUTO_RELOAD_EN
    check("auto reload time", ch_time(0), 32'h000003);
    check("auto reload run", 32'(bus.running[0]), 32'h1);
`else
    check("no reload time", ch_time(0), 32'h000000);
    check("no reload idle", 32'(bus.running[0]), 32'h0);
`endif

    clocks(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_countdown_timer.md
Name: multi_countdown_timer

Overview:
- Parametrised successor to the single-channel BCD countdown timer.
- Holds CHANNELS independent HH:MM:SS BCD countdowns in one 1 Hz clock domain.
- Each channel has load/start/pause control, load validation and a timed buzzer with acknowledge.
- Sits between the keypad/mode controller and the display mux / buzzer driver of the clock.

Parameters:
- CHANNELS, 2, number of independent countdown channels (1..8).
- BUZZ_SECS, 5, buzzer on-time in clk_1hz cycles after expiry (1..255).
- CH_W, 1, width of ch_sel. Set to max(1, ceil(log2(CHANNELS))).

Ports:
- clk_1hz  input  1  1 Hz system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- timer_mode  input  2  command to the selected channel: 00 none, 01 load, 10 start/ack, 11 pause.
- ch_sel  input  CH_W  target channel of timer_mode.
- time_in  input  24  load value {hour, min, sec}, 8-bit packed BCD each.
- time_out  output  24*CHANNELS  channel k at bits [24k+23:24k], format {hour, min, sec} BCD.
- buzzer  output  CHANNELS  per-channel alarm, high while the channel is in ALARM.
- running  output  CHANNELS  per-channel, high while the channel is in RUN.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (synchronous, active-high): every channel time = 00:00:00, state IDLE, buzz counter 0. All buzzer/running bits 0, load_err 0. Reset has priority over any command.
- Per-channel FSM, three states:
  - IDLE: time held.
  - RUN: time decrements once per clk_1hz.
  - ALARM: time held at 00:00:00, buzzer high.
- Command decode, applied only to channel ch_sel. Other channels continue unaffected in the same cycle. ch_sel >= CHANNELS: command ignored, load_err not pulsed.
- Load (01), valid: time_in loaded; state -> IDLE from any state. A load in RUN or ALARM aborts that state.
  - Valid means every nibble <= 9, sec <= 0x59, min <= 0x59; hour is 00..99.
- Load (01), invalid: time and state unchanged; load_err = 1 for exactly the next cycle.
- Start/ack (10):
  - IDLE with time != 0 -> RUN; first decrement on the following edge.
  - IDLE with time == 0: ignored.
  - ALARM: silence. Buzzer 0 next cycle, state -> IDLE.
  - RUN: no effect.
- Pause (11): RUN -> IDLE with time frozen; ignored in other states.
- Decrement in RUN, BCD borrow chain:
  - Seconds: sec != 00 -> sec - 1 (x0 -> (x-1)9).
  - Minutes: sec == 00 and min != 00 -> sec = 59, min - 1.
  - Hours: sec == 00 and min == 00 -> sec = 59, min = 59, hour - 1 (BCD borrow, 10 -> 09, 20 -> 19, etc.).
  - Never wraps below 00:00:00.
- Expiry: on the edge where time goes 00:00:01 -> 00:00:00, state -> ALARM and buzz counter = BUZZ_SECS.
  - buzzer and running outputs are registered state decodes, so buzzer rises on that same edge.
- ALARM: buzz counter decrements each cycle. Buzzer stays high for exactly BUZZ_SECS cycles, then state -> IDLE (unless acknowledged earlier).
- Pause and start in the same cycle are impossible (single encoded command).
- A command and an expiry on the same channel in the same cycle: the command wins. A load or pause on the last RUN cycle prevents ALARM.
- running and buzzer are never high together for one channel.

Optional Feature:
- Macro: MULTI_TIMER_AUTO_RELOAD_EN.
- Defined: each channel keeps a reload register, written on every valid load. When ALARM ends by buzz-counter timeout, time = reload value and state -> RUN (periodic timer); first decrement on the next edge.
  - If the reload value is 00:00:00 -> IDLE.
  - Ack (10) in ALARM still -> IDLE without reload.
  - Reset clears reload registers to 0.
- Undefined: no reload register; after timeout the channel stays IDLE at 00:00:00.

Test Plan:
- Reset, then load ch0 = 00:01:05, start, 6 clocks -> ch0 = 00:00:59; ch1 stays 00:00:00 IDLE; running = 01.
- Load ch1 = 01:00:00, start, 1 clock -> 00:59:59; hour borrow 20:00:00 -> 19:59:59.
- Load ch0 = 00:00:02, start -> expires after 2 clocks; buzzer[0] high exactly BUZZ_SECS = 5 cycles, then IDLE, time 00:00:00. Repeat with ack on cycle 2 -> buzzer low next cycle.
- Load ch0 = 00:00:10, start, 3 clocks, pause, 4 clocks -> time frozen at 00:00:07; start resumes to 00:00:06 next clock.
- Load 00:5A:00, and separately 00:60:00 -> load_err single-cycle pulse, time unchanged. ch_sel = 3 with CHANNELS = 2 -> no effect, no load_err.
- With MULTI_TIMER_AUTO_RELOAD_EN: load 00:00:03, start -> after expiry plus 5 buzzer cycles, time = 00:00:03 and running = 1. Without the macro -> IDLE at 00:00:00.
